// File: rtl/page_walker_if.sv
// Bundle between the page walker, its TLB/coprocessor requester and the memory bus.
// The walker uses the slave modport; the requester/memory side uses master.
interface page_walker_if;
    logic [31:0] ptb_i;
    logic        ptb_we_i;
    logic        walk_req_i;
    logic [31:0] walk_vaddr_i;
    logic        walk_busy_o;
    logic        walk_done_o;
    logic [31:0] walk_pte_o;
    logic        mem_re_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ready_i;
    logic        page_fault_o;
    logic [31:0] page_fault_addr_o;

    modport slave (
        input  ptb_i, ptb_we_i, walk_req_i, walk_vaddr_i, mem_data_i, mem_ready_i,
        output walk_busy_o, walk_done_o, walk_pte_o, mem_re_o, mem_addr_o,
               page_fault_o, page_fault_addr_o
    );

    modport master (
        output ptb_i, ptb_we_i, walk_req_i, walk_vaddr_i, mem_data_i, mem_ready_i,
        input  walk_busy_o, walk_done_o, walk_pte_o, mem_re_o, mem_addr_o,
               page_fault_o, page_fault_addr_o
    );
endinterface

// File: rtl/page_walker.sv
// Two-level (10/10/12) hardware page-table walker with a single-entry PDE cache.
// Every output is registered from the next-state logic, so pulses appear the cycle after the event.
module page_walker (
    input  logic          clk,
    input  logic          rst,
    page_walker_if.slave  bus
);
    localparam int unsigned PFN_W = 20;
    localparam int unsigned TAG_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PDE  = 2'd1,
        ST_PTE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        va_q, va_d;
    logic [PFN_W-1:0]   ptb_q, ptb_d;
    logic [PFN_W-1:0]   pde_q, pde_d;
    logic               suppress_q, suppress_d;
    logic               cvalid_q, cvalid_d;
    logic [TAG_W-1:0]   ctag_q, ctag_d;
    logic [PFN_W-1:0]   cpde_q, cpde_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        pte_q, pte_d;
    logic               re_q, re_d;
    logic [31:0]        addr_q, addr_d;
    logic               fault_q, fault_d;
    logic [31:0]        faddr_q, faddr_d;
    logic               hit_c;

    // Only the page-frame bits of the PTB register matter.
    logic unused_ptb_low;
    assign unused_ptb_low = ^bus.ptb_i[11:0];

    // A PTB write in the accept cycle also makes the cached PDE stale.
    assign hit_c = cvalid_q && !bus.ptb_we_i &&
                   (ctag_q == bus.walk_vaddr_i[31:22]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            va_q       <= '0;
            ptb_q      <= '0;
            pde_q      <= '0;
            suppress_q <= 1'b0;
            cvalid_q   <= 1'b0;
            ctag_q     <= '0;
            cpde_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pte_q      <= '0;
            re_q       <= 1'b0;
            addr_q     <= '0;
            fault_q    <= 1'b0;
            faddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            va_q       <= va_d;
            ptb_q      <= ptb_d;
            pde_q      <= pde_d;
            suppress_q <= suppress_d;
            cvalid_q   <= cvalid_d;
            ctag_q     <= ctag_d;
            cpde_q     <= cpde_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pte_q      <= pte_d;
            re_q       <= re_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
            faddr_q    <= faddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        va_d       = va_q;
        ptb_d      = ptb_q;
        pde_d      = pde_q;
        suppress_d = suppress_q | bus.ptb_we_i;
        cvalid_d   = cvalid_q & ~bus.ptb_we_i;
        ctag_d     = ctag_q;
        cpde_d     = cpde_q;
        re_d       = 1'b0;
        addr_d     = '0;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        pte_d      = pte_q;
        faddr_d    = faddr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.walk_req_i) begin
                    va_d       = bus.walk_vaddr_i;
                    ptb_d      = bus.ptb_i[31:12];
                    suppress_d = bus.ptb_we_i;
                    re_d       = 1'b1;
                    if (hit_c) begin
                        pde_d   = cpde_q;
                        state_d = ST_PTE;
                        addr_d  = {cpde_q, bus.walk_vaddr_i[21:12], 2'b00};
                    end else begin
                        state_d = ST_PDE;
                        addr_d  = {bus.ptb_i[31:12], bus.walk_vaddr_i[31:22], 2'b00};
                    end
                end
            end

            ST_PDE: begin
                re_d   = 1'b1;
                addr_d = {ptb_q, va_q[31:22], 2'b00};
                if (bus.mem_ready_i) begin
                    if (bus.mem_data_i[0]) begin
                        pde_d   = bus.mem_data_i[31:12];
                        state_d = ST_PTE;
                        addr_d  = {bus.mem_data_i[31:12], va_q[21:12], 2'b00};
                        // Any PTB write since acceptance (including this cycle) blocks the fill.
                        if (!suppress_q && !bus.ptb_we_i) begin
                            cvalid_d = 1'b1;
                            ctag_d   = va_q[31:22];
                            cpde_d   = bus.mem_data_i[31:12];
                        end
                    end else begin
                        re_d    = 1'b0;
                        addr_d  = '0;
                        fault_d = 1'b1;
                        faddr_d = va_q;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_PTE: begin
                re_d   = 1'b1;
                addr_d = {pde_q, va_q[21:12], 2'b00};
                if (bus.mem_ready_i) begin
                    re_d    = 1'b0;
                    addr_d  = '0;
                    state_d = ST_IDLE;
                    if (bus.mem_data_i[0]) begin
                        done_d = 1'b1;
                        pte_d  = bus.mem_data_i;
                    end else begin
                        fault_d = 1'b1;
                        faddr_d = va_q;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.walk_busy_o       = busy_q;
    assign bus.walk_done_o       = done_q;
    assign bus.walk_pte_o        = pte_q;
    assign bus.mem_re_o          = re_q;
    assign bus.mem_addr_o        = addr_q;
    assign bus.page_fault_o      = fault_q;
    assign bus.page_fault_addr_o = faddr_q;
endmodule

// File: tb/tb_page_walker.sv
// Self-checking bench for page_walker: table of walks against a scripted memory,
// a pulse scoreboard, and hand-written PTB-write and reset-mid-walk sequences.
module tb_page_walker;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    page_walker_if bus ();

    page_walker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] ptb;
        logic [31:0] va;
        logic [31:0] pde_addr;
        logic [31:0] pde_data;
        logic [31:0] pte_addr;
        logic [31:0] pte_data;
        int          waitc;
        int          we_off;
        logic [31:0] new_ptb;
        logic        exp_fault;
        logic [31:0] exp_val;
        int          exp_lat;
        int          exp_nreads;
        logic [31:0] exp_first;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] val;
        int          cyc;
        logic [31:0] hold;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } rd_t;

    vec_t        tab [8];
    exp_t        exp_q [$];
    rd_t         reads_q [$];
    exp_t        e;
    logic [31:0] last_pte;

    logic [31:0] m_pde_addr, m_pde_data, m_pte_addr, m_pte_data;
    int          mem_wait;
    int          wait_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scripted memory: ready after mem_wait stall cycles of a held request.
    always_comb begin
        bus.mem_ready_i = bus.mem_re_o && (wait_cnt >= mem_wait);
        bus.mem_data_i  = 32'hDEAD_BEEE;
        if (bus.mem_ready_i) begin
            if (bus.mem_addr_o == m_pde_addr)      bus.mem_data_i = m_pde_data;
            else if (bus.mem_addr_o == m_pte_addr) bus.mem_data_i = m_pte_data;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_re_o && !bus.mem_ready_i) wait_cnt <= wait_cnt + 1;
        else                                  wait_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: logs completed reads and scores done/fault pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_re_o && bus.mem_ready_i)
                reads_q.push_back('{addr: bus.mem_addr_o, cyc: cyc});
            if (bus.walk_done_o || bus.page_fault_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b fault=%0b with nothing expected (cycle %0d)",
                             bus.walk_done_o, bus.page_fault_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_exclusive", 32'(bus.walk_done_o & bus.page_fault_o), 32'd0);
                    chk("pulse_kind_fault", 32'(bus.page_fault_o), 32'(e.fault));
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.fault) begin
                        chk("fault_addr", bus.page_fault_addr_o, e.val);
                        chk("pte_hold_on_fault", bus.walk_pte_o, e.hold);
                    end else begin
                        chk("walk_pte", bus.walk_pte_o, e.val);
                    end
                end
            end
        end
    end

    task automatic run_walk(input vec_t v);
        int  n0;
        bit  seen;
        @(negedge clk);
        m_pde_addr = v.pde_addr;
        m_pde_data = v.pde_data;
        m_pte_addr = v.pte_addr;
        m_pte_data = v.pte_data;
        mem_wait   = v.waitc;
        bus.ptb_i  = v.ptb;
        reads_q.delete();
        n0 = cyc;
        exp_q.push_back('{fault: v.exp_fault, val: v.exp_val, cyc: n0 + v.exp_lat, hold: last_pte});
        bus.walk_req_i   = 1'b1;
        bus.walk_vaddr_i = v.va;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (cyc - n0 == v.we_off) begin
                bus.ptb_we_i = 1'b1;
                bus.ptb_i    = v.new_ptb;
            end else begin
                bus.ptb_we_i = 1'b0;
            end
            if (bus.walk_done_o || bus.page_fault_o) seen = 1;
        end
        bus.walk_req_i = 1'b0;
        bus.ptb_we_i   = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL walk_timeout: va 0x%08h got no pulse within 60 cycles, expected one", v.va);
            exp_q.delete();
        end else begin
            chk("idle_busy", 32'(bus.walk_busy_o), 32'd0);
            chk("idle_mem_re", 32'(bus.mem_re_o), 32'd0);
            chk("idle_mem_addr", bus.mem_addr_o, 32'd0);
            chk("read_count", 32'(reads_q.size()), 32'(v.exp_nreads));
            if (reads_q.size() > 0) begin
                chk("first_read_addr", reads_q[0].addr, v.exp_first);
                chk("first_read_cycle", 32'(reads_q[0].cyc), 32'(n0 + 1 + v.waitc));
            end
            if (!v.exp_fault) last_pte = v.exp_val;
        end
    endtask

    initial begin
        int n0;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        wait_cnt = 0;
        mem_wait = 0;
        last_pte = 32'd0;
        m_pde_addr = 32'hFFFF_FFF0; m_pde_data = 32'd0;
        m_pte_addr = 32'hFFFF_FFF0; m_pte_data = 32'd0;

        //            ptb           va            pde_addr      pde_data      pte_addr      pte_data     wait we new_ptb       fault val           lat nrd first
        tab[0] = '{32'h00100000, 32'h00800ABC, 32'h00100008, 32'h00200000, 32'h00000000, 32'h00000000, 0, -1, 32'h0, 1'b1, 32'h00800ABC, 2, 1, 32'h00100008};
        tab[1] = '{32'h00100000, 32'h00801000, 32'h00100008, 32'h00500001, 32'h00500004, 32'h0FEDC001, 0, -1, 32'h0, 1'b0, 32'h0FEDC001, 3, 2, 32'h00100008};
        tab[2] = '{32'h00100000, 32'h00403123, 32'h00100004, 32'h00200001, 32'h0020000C, 32'h12345007, 0, -1, 32'h0, 1'b0, 32'h12345007, 3, 2, 32'h00100004};
        tab[3] = '{32'h00100000, 32'h00405000, 32'h00100004, 32'h00200001, 32'h00200014, 32'h0ABCD003, 0, -1, 32'h0, 1'b0, 32'h0ABCD003, 2, 1, 32'h00200014};
        tab[4] = '{32'h00100000, 32'h00C07000, 32'h0010000C, 32'h00300001, 32'h0030001C, 32'h12345006, 0, -1, 32'h0, 1'b1, 32'h00C07000, 3, 2, 32'h0010000C};
        tab[5] = '{32'h00100000, 32'h01002000, 32'h00100010, 32'h00600001, 32'h00600008, 32'h0AAAA001, 3,  2, 32'h00700000, 1'b0, 32'h0AAAA001, 9, 2, 32'h00100010};
        tab[6] = '{32'h00700000, 32'h01003000, 32'h00700010, 32'h00600001, 32'h0060000C, 32'h0BBBB001, 0, -1, 32'h0, 1'b0, 32'h0BBBB001, 3, 2, 32'h00700010};
        tab[7] = '{32'h00700000, 32'h01401000, 32'h00700014, 32'h00800001, 32'h00800004, 32'h0DDDD001, 0, -1, 32'h0, 1'b0, 32'h0DDDD001, 3, 2, 32'h00700014};

        rst              = 1'b1;
        bus.ptb_i        = 32'd0;
        bus.ptb_we_i     = 1'b0;
        bus.walk_req_i   = 1'b0;
        bus.walk_vaddr_i = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.walk_busy_o), 32'd0);
        chk("rst_done", 32'(bus.walk_done_o), 32'd0);
        chk("rst_pte", bus.walk_pte_o, 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_fault", 32'(bus.page_fault_o), 32'd0);
        chk("rst_fault_addr", bus.page_fault_addr_o, 32'd0);

        // PDE fault, uncached re-walk, basic walk, cache hit, PTE fault, wait states + PTB write, reread.
        for (int i = 0; i < 7; i++) run_walk(tab[i]);

        // Reset during the PTE wait of a waited miss walk in a fresh region.
        @(negedge clk);
        m_pde_addr = 32'h00700014; m_pde_data = 32'h00800001;
        m_pte_addr = 32'h00800000; m_pte_data = 32'h0CCCC001;
        mem_wait   = 3;
        bus.ptb_i  = 32'h00700000;
        n0 = cyc;
        bus.walk_req_i   = 1'b1;
        bus.walk_vaddr_i = 32'h01400000;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) chk("pre_rst_in_pte_read", bus.mem_addr_o, 32'h00800000);
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                rst = 1'b0;
                bus.walk_req_i = 1'b0;
                chk("midrst_mem_re", 32'(bus.mem_re_o), 32'd0);
                chk("midrst_busy", 32'(bus.walk_busy_o), 32'd0);
                chk("midrst_done", 32'(bus.walk_done_o), 32'd0);
                chk("midrst_fault", 32'(bus.page_fault_o), 32'd0);
                chk("midrst_pte", bus.walk_pte_o, 32'd0);
                chk("midrst_cycle", 32'(cyc), 32'(n0 + 7));
            end
        end
        last_pte = 32'd0;
        repeat (2) @(negedge clk);
        run_walk(tab[7]);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/page_walker.md
# page_walker

Hardware two-level page-table walker that sits between the TLB/MMU and the memory bus, configured by the coprocessor's page-table-base register. On a translation miss it fetches the page-directory entry and the page-table entry, returns the PTE on success, or raises a page fault with the faulting virtual address for the coprocessor to latch. A single-entry PDE cache skips the directory read when consecutive misses fall in the same 4 MiB region.

## Interface
- No parameters. Page size 4 KiB; VA split is 10/10/12.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ptb_i  in  32  page-table base from the coprocessor; bits [31:12] are used
- ptb_we_i  in  1  pulse when software writes the PTB; invalidates the PDE cache
- walk_req_i  in  1  miss request; sampled only in IDLE
- walk_vaddr_i  in  32  faulting/missing virtual address; valid with walk_req_i
- walk_busy_o  out  1  high in every non-IDLE state
- walk_done_o  out  1  one-cycle pulse: walk_pte_o valid
- walk_pte_o  out  32  resulting PTE; holds until the next done
- mem_re_o  out  1  memory read request; held until mem_ready_i
- mem_addr_o  out  32  word address of the entry being read
- mem_data_i  in  32  read data; valid in the cycle mem_ready_i=1
- mem_ready_i  in  1  read complete; may rise in the same cycle as mem_re_o
- page_fault_o  out  1  one-cycle pulse: translation failed
- page_fault_addr_o  out  32  faulting VA; holds until the next fault

## Operation
- States: IDLE, PDE, PTE.
- IDLE, walk_req_i=1: latch the VA and the current ptb_i[31:12].
  - If the PDE cache is valid and its tag equals VA[31:22], go to PTE using the cached PDE.
  - Otherwise go to PDE.
- PDE: mem_re_o=1, mem_addr_o={ptb[31:12], VA[31:22], 2'b00}. On mem_ready_i:
  - mem_data_i[0]=0: pulse page_fault_o with page_fault_addr_o=VA, go to IDLE. The PDE is not cached.
  - mem_data_i[0]=1: store the PDE, fill the cache (tag VA[31:22]) unless suppressed, go to PTE.
- PTE: mem_re_o=1, mem_addr_o={pde[31:12], VA[21:12], 2'b00}. On mem_ready_i:
  - mem_data_i[0]=0: fault as in PDE.
  - mem_data_i[0]=1: walk_pte_o=mem_data_i, pulse walk_done_o.
  - Either way, go to IDLE.
- walk_done_o and page_fault_o are never high together.
- ptb_we_i in any state clears the cache valid bit.
  - If it occurs during a walk, that walk completes with the latched PTB but its PDE cache fill is suppressed.
  - If it coincides with a fill, the invalidation wins.
- walk_req_i outside IDLE is ignored; the requester holds it until done or fault.
- mem_addr_o is 0 in IDLE.

## Timing
- Reset values: state IDLE, cache invalid; all outputs 0 (walk_busy_o, walk_done_o, walk_pte_o, mem_re_o, mem_addr_o, page_fault_o, page_fault_addr_o).
- Accept in cycle N. Cache miss: mem_re_o=1 for the PDE read from N+1.
- With zero-wait memory (ready in the same cycle as the request):
  - Cache miss: PTE read at N+2; done/fault at N+3, state IDLE in N+3. A new request can be accepted at N+3.
  - Cache hit: PTE read at N+1; done at N+2.
  - PDE fault: page_fault_o at N+2.
- Each memory wait cycle adds one cycle of latency. mem_addr_o is stable while mem_re_o is high.
- Outputs are registered; pulses last exactly one cycle.
- rst mid-walk: returns to IDLE next cycle, drops mem_re_o, invalidates the cache, emits no pulse.

## Test plan
- Basic walk, ptb=0x00100000, VA=0x00403123, zero-wait memory.
  - Reads at 0x00100004 (returns 0x00200001), then 0x0020000C (returns 0x12345007).
  - Required: walk_done_o at N+3, walk_pte_o=0x12345007.
- Cache hit: after the basic walk, VA=0x00405000.
  - The only read is at 0x00200014, at N+1. done at N+2.
- PDE fault: PDE read returns 0x00200000.
  - page_fault_o at N+2, page_fault_addr_o=VA, no PTE read, cache still invalid.
- PTE fault: PTE read returns 0x12345006.
  - page_fault_o at N+3, walk_done_o stays 0, walk_pte_o unchanged.
- Wait states and PTB write: mem_ready_i delayed 3 cycles per read, with ptb_we_i pulsed during the PDE wait.
  - Walk completes at N+9 using the old PTB.
  - The next walk in the same region rereads the PDE.
- Reset mid-walk: rst asserted in the PTE wait.
  - Next cycle: mem_re_o=0, walk_busy_o=0, no pulse; the next request misses the cache.
